period_meas_sched: RTL and testbench
====================================

# period_meas_sched

Round-robin scheduler that shares one edge-interval counter among up to CHANNELS clock signals, for example PLL outputs CLKOUT0..5. For each requesting channel it selects the signal, flushes the synchronizer, and discards settling edges. It then averages 2^AVG_LOG2 periods measured in clk ticks and reports one result per measurement. It sits between the PLL output clocks and the lock/frequency-check logic that consumes per-channel period values.

## Interface
- CHANNELS, 6: number of measured signals (2..16).
- WIDTH, 32: tick counter and result width.
- DISCARD, 2: rising edges discarded after a channel switch (0..15).
- AVG_LOG2, 2: log2 of the number of periods averaged (0..4).
- TIMEOUT, 65535: clk cycles without a selected edge before a measurement is declared dead.
- clk  in  1  measurement time base; all outputs are synchronous to it.
- RST  in  1  reset, asynchronous, active-high; clock clk.
- PWRDWN  in  1  synchronous to clk; forces IDLE and suppresses reporting.
- sig_in  in  CHANNELS  measured signals, asynchronous to clk.
- req  in  CHANNELS  level request per channel.
- sel  out  clog2(CHANNELS)  channel currently owning the counter.
- busy  out  1  high in every state except IDLE.
- result  out  WIDTH  averaged period in clk ticks; holds its value until the next report.
- result_ch  out  clog2(CHANNELS)  channel that `result` belongs to.
- result_valid  out  1  one-cycle pulse when a result is reported.
- timeout  out  1  one-cycle pulse coincident with result_valid when the measurement died; `result` is 0 in that case.

## Operation
- Each sig_in bit passes through its own 2-FF synchronizer. The selected synchronized bit is registered once more, and a rising-edge strobe is generated from it.
- States:
  - IDLE: if any req bit is set and PWRDWN is 0, grant the next channel and go to SWITCH.
  - SWITCH: sel is updated on entry; wait 3 cycles for the synchronizer and mux pipeline to flush, then go to DISCARD, or straight to MEASURE when DISCARD = 0.
  - DISCARD: count DISCARD edges. The last discarded edge starts the interval counter, then go to MEASURE.
  - MEASURE: on each edge, add the interval to the accumulator and restart the interval counter. After 2^AVG_LOG2 intervals, go to REPORT.
  - REPORT: one cycle. Drive result = accumulator >> AVG_LOG2 and result_ch = sel, pulse result_valid, then return to IDLE.
- When DISCARD = 0, the first edge seen in MEASURE only starts the interval counter; it adds nothing to the accumulator.
- Round-robin grant: the grant goes to the lowest index above last_served that has req set, wrapping around to index 0. last_served updates in REPORT.
- Saturation: the interval counter and the (WIDTH+AVG_LOG2)-bit accumulator both saturate at all-ones and never wrap.
- Timeout: if the interval counter reaches TIMEOUT in DISCARD or MEASURE, go to REPORT with result = 0 and timeout = 1.
- Abort: if req[sel] drops, or PWRDWN rises, in SWITCH, DISCARD or MEASURE, return to IDLE on the next cycle. No report is made and last_served is unchanged.
- Simultaneous events: PWRDWN takes priority over timeout, and timeout takes priority over an edge in the same cycle.

## Timing
- Reset values: sel = 0, busy = 0, result = 0, result_ch = 0, result_valid = 0, timeout = 0, last_served = CHANNELS-1 (so channel 0 is served first), state = IDLE, all counters 0.
- req to busy: 1 cycle.
- sig_in edge to edge strobe: 3 to 4 clk cycles; the latency is identical for every edge, so intervals are exact to ±1 tick.
- After the final MEASURE edge, result_valid asserts on the next cycle.
- A new grant can be issued in the cycle after REPORT.
- Intervals are exact when the sig_in period is at least 2 clk cycles. Shorter periods are not supported.

## Structure
- Package period_meas_pkg:
  - state enum (IDLE, SWITCH, DISCARD, MEASURE, REPORT);
  - SYNC_STAGES = 2 and SWITCH_CYCLES = 3;
  - a sel-width function (clog2 with a minimum of 1).
- Sub-module edge_interval_counter owns the saturating interval counter and the timeout compare.
  - Inputs: clk, RST, restart, edge.
  - Outputs: interval and expired.
- The synchronizers, edge detect, FSM, accumulator and arbiter live in period_meas_sched.

## Test plan
- Single channel, CHANNELS = 6, DISCARD = 2, AVG_LOG2 = 2: clk period 10 ns, sig_in[0] period 80 ns, req = 000001 → one result_valid with result = 8 and result_ch = 0, timeout = 0.
- Round robin: req = 100101, all channels at 40 ns → results reported in channel order 0, 2, 5, 0 with result = 4 each.
- Stopped clock: sig_in[3] held low, TIMEOUT = 100, req = 001000 → result_valid and timeout together with result = 0, reported 3 + 100 ± 4 cycles after the grant.
- Abort: req[1] dropped mid-MEASURE → return to IDLE within 1 cycle with no result_valid. Re-asserting req[1] yields a full fresh measurement.
- PWRDWN pulse during DISCARD while req stays high → no report, busy falls, and measurement restarts on the same channel after PWRDWN falls.
- Async RST asserted mid-MEASURE → all outputs read their reset values immediately, and the next grant goes to channel 0.

Source files
------------

// File: rtl/period_meas_pkg.sv
// Shared definitions for the period measurement scheduler.
//   state_e        : scheduler FSM states
//   SYNC_STAGES    : flip-flops in each sig_in synchronizer
//   SWITCH_CYCLES  : cycles spent flushing the synchronizer/mux after a channel switch
//   sel_width()    : width of a channel index (clog2, at least 1)
package period_meas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SWITCH,
      ST_DISCARD,
      ST_MEASURE,
      ST_REPORT
   } state_e;

   localparam int unsigned SYNC_STAGES   = 2;
   localparam int unsigned SWITCH_CYCLES = 3;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_interval_counter.sv
// Saturating clk-tick counter measuring the time between edge strobes.
//   clk, RST    : clock, asynchronous active-high reset
//   restart_i   : hold the counter at zero (channel not being measured)
//   edge_i      : qualified edge strobe; the count restarts so that the next
//                 edge reads exactly the number of clk cycles in between
//   interval_o  : ticks since the last edge (or since restart was released)
//   expired_o   : interval has reached TIMEOUT
module edge_interval_counter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             restart_i,
   input  logic             edge_i,
   output logic [WIDTH-1:0] interval_o,
   output logic             expired_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // An edge loads 1, not 0: the edge cycle itself is the first tick of the
   // new interval, so the following edge samples the exact cycle distance.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (edge_i) begin
         cnt_d = WIDTH'(1);
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign interval_o = cnt_q;
   assign expired_o  = (cnt_q >= WIDTH'(TIMEOUT));

endmodule

// File: rtl/period_meas_sched.sv
// Round-robin scheduler sharing one edge-interval counter among CHANNELS
// asynchronous clock signals; reports the average of 2^AVG_LOG2 periods.
//   clk, RST      : time base, asynchronous active-high reset
//   PWRDWN        : forces IDLE, aborts any measurement without a report
//   sig_in        : measured signals (asynchronous)
//   req           : level request per channel
//   sel           : channel currently owning the counter
//   busy          : FSM not in IDLE
//   result        : averaged period in clk ticks (0 on timeout), held
//   result_ch     : channel that result belongs to
//   result_valid  : one-cycle report strobe
//   timeout       : with result_valid, measurement died (no edges)
module period_meas_sched
   import period_meas_pkg::*;
#(
   parameter int unsigned CHANNELS = 6,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DISCARD  = 2,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic                              clk,
   input  logic                              RST,
   input  logic                              PWRDWN,
   input  logic [CHANNELS-1:0]               sig_in,
   input  logic [CHANNELS-1:0]               req,
   output logic [sel_width(CHANNELS)-1:0]    sel,
   output logic                              busy,
   output logic [WIDTH-1:0]                  result,
   output logic [sel_width(CHANNELS)-1:0]    result_ch,
   output logic                              result_valid,
   output logic                              timeout
);

   localparam int unsigned SW    = sel_width(CHANNELS);
   localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
   localparam int unsigned AVG_N = 1 << AVG_LOG2;
   localparam int unsigned MCW   = AVG_LOG2 + 1;

   state_e                               state_q;
   logic [SW-1:0]                        sel_q;
   logic [SW-1:0]                        last_served_q;
   logic                                 busy_q;
   logic [WIDTH-1:0]                     result_q;
   logic [SW-1:0]                        result_ch_q;
   logic                                 result_valid_q;
   logic                                 timeout_q;
   logic [1:0]                           sw_cnt_q;
   logic [3:0]                           disc_cnt_q;
   logic [MCW-1:0]                       meas_cnt_q;
   logic [ACC_W-1:0]                     acc_q;
   logic                                 first_q;

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
   logic                                 sel_bit_q;
   logic                                 sel_prev_q;

   logic                                 measuring;
   logic                                 edge_q;
   logic                                 abort;
   logic [WIDTH-1:0]                     interval;
   logic                                 expired;
   logic [ACC_W:0]                       acc_sum;
   logic [ACC_W-1:0]                     acc_d;
   logic [WIDTH-1:0]                     avg_d;
   logic                                 grant_found;
   logic [SW-1:0]                        grant_d;
   logic [SW:0]                          idx_w;

   // Synchronizers and selected-channel edge detect
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         sync_q     <= '0;
         sel_bit_q  <= 1'b0;
         sel_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
         sel_bit_q  <= sync_q[SYNC_STAGES-1][sel_q];
         sel_prev_q <= sel_bit_q;
      end
   end

   // Edges are only honoured once the post-switch flush is over, so the
   // stale mux output of the previous channel can never produce a strobe.
   assign measuring = (state_q == ST_DISCARD) || (state_q == ST_MEASURE);
   assign edge_q    = sel_bit_q & ~sel_prev_q & measuring;
   assign abort     = PWRDWN | ~req[sel_q];

   edge_interval_counter #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_counter (
      .clk        (clk),
      .RST        (RST),
      .restart_i  (~measuring),
      .edge_i     (edge_q),
      .interval_o (interval),
      .expired_o  (expired)
   );

   // Saturating accumulate of the interval ending at this edge
   always_comb begin
      acc_sum = {1'b0, acc_q} + (ACC_W+1)'(interval);
      acc_d   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      avg_d   = acc_d[ACC_W-1:AVG_LOG2];
   end

   // Round-robin: first requester strictly after last_served, wrapping
   always_comb begin
      grant_found = 1'b0;
      grant_d     = '0;
      idx_w       = '0;
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
         idx_w = {1'b0, last_served_q} + (SW+1)'(i);
         if (idx_w >= (SW+1)'(CHANNELS)) begin
            idx_w = idx_w - (SW+1)'(CHANNELS);
         end
         if (!grant_found && req[idx_w[SW-1:0]]) begin
            grant_found = 1'b1;
            grant_d     = idx_w[SW-1:0];
         end
      end
   end

   // Scheduler FSM; abort outranks timeout, timeout outranks an edge
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         sel_q          <= '0;
         last_served_q  <= SW'(CHANNELS-1);
         busy_q         <= 1'b0;
         result_q       <= '0;
         result_ch_q    <= '0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         sw_cnt_q       <= '0;
         disc_cnt_q     <= '0;
         meas_cnt_q     <= '0;
         acc_q          <= '0;
         first_q        <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!PWRDWN && grant_found) begin
                  state_q  <= ST_SWITCH;
                  sel_q    <= grant_d;
                  busy_q   <= 1'b1;
                  sw_cnt_q <= '0;
               end
            end
            ST_SWITCH: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (sw_cnt_q == 2'(SWITCH_CYCLES-1)) begin
                  disc_cnt_q <= '0;
                  meas_cnt_q <= '0;
                  acc_q      <= '0;
                  first_q    <= (DISCARD == 0);
                  state_q    <= (DISCARD == 0) ? ST_MEASURE : ST_DISCARD;
               end else begin
                  sw_cnt_q <= sw_cnt_q + 2'd1;
               end
            end
            ST_DISCARD: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (expired) begin
                  state_q        <= ST_REPORT;
                  result_q       <= '0;
                  result_ch_q    <= sel_q;
                  result_valid_q <= 1'b1;
                  timeout_q      <= 1'b1;
               end else if (edge_q) begin
                  // The last discarded edge has already restarted the counter.
                  if (disc_cnt_q == 4'(DISCARD-1)) begin
                     state_q <= ST_MEASURE;
                  end else begin
                     disc_cnt_q <= disc_cnt_q + 4'd1;
                  end
               end
            end
            ST_MEASURE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (expired) begin
                  state_q        <= ST_REPORT;
                  result_q       <= '0;
                  result_ch_q    <= sel_q;
                  result_valid_q <= 1'b1;
                  timeout_q      <= 1'b1;
               end else if (edge_q) begin
                  if (first_q) begin
                     first_q <= 1'b0;
                  end else if (meas_cnt_q == MCW'(AVG_N-1)) begin
                     state_q        <= ST_REPORT;
                     result_q       <= avg_d;
                     result_ch_q    <= sel_q;
                     result_valid_q <= 1'b1;
                  end else begin
                     acc_q      <= acc_d;
                     meas_cnt_q <= meas_cnt_q + MCW'(1);
                  end
               end
            end
            ST_REPORT: begin
               last_served_q <= sel_q;
               state_q       <= ST_IDLE;
               busy_q        <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sel          = sel_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_ch    = result_ch_q;
   assign result_valid = result_valid_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_period_meas_sched.sv
// Self-checking bench for period_meas_sched (6 channels, TIMEOUT = 100).
module tb_period_meas_sched;

   logic        clk = 1'b0;
   logic        RST;
   logic        PWRDWN;
   logic [5:0]  sig_in;
   logic [5:0]  req;
   logic [2:0]  sel;
   logic        busy;
   logic [31:0] result;
   logic [2:0]  result_ch;
   logic        result_valid;
   logic        timeout;

   int errors = 0;
   int checks = 0;
   int per [6];          // signal period in clk ticks, 0 = stopped
   int last_served;      // reference-model round-robin pointer

   typedef struct {
      logic [5:0] rq;
      int         ch;
      int         period;
      int         exp_res;
      bit         exp_to;
   } vec_t;
   vec_t tbl [6];

   period_meas_sched #(
      .CHANNELS (6),
      .WIDTH    (32),
      .DISCARD  (2),
      .AVG_LOG2 (2),
      .TIMEOUT  (100)
   ) dut (
      .clk          (clk),
      .RST          (RST),
      .PWRDWN       (PWRDWN),
      .sig_in       (sig_in),
      .req          (req),
      .sel          (sel),
      .busy         (busy),
      .result       (result),
      .result_ch    (result_ch),
      .result_valid (result_valid),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Signal generator: channel g rises at phase(g) + k*per*10, 50% duty.
   // Phases 1..4 keep every edge away from clk rising edges (5 mod 10).
   initial begin
      longint t;
      longint p;
      sig_in = '0;
      forever begin
         #1;
         for (int g = 0; g < 6; g++) begin
            t = longint'($time) - longint'(g % 4 + 1);
            p = longint'(per[g]) * 10;
            sig_in[g] = (p > 0) && (t >= 0) && ((t % p) < (p / 2));
         end
      end
   end

   function automatic int next_grant(input int last, input logic [5:0] m);
      int idx;
      for (int i = 1; i <= 6; i++) begin
         idx = (last + i) % 6;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic wait_valid(input int maxc, output bit got, output int n);
      got = 1'b0;
      n   = 0;
      while (n < maxc && !got) begin
         @(negedge clk);
         n++;
         if (result_valid) got = 1'b1;
      end
   endtask

   task automatic wait_busy(input string nm);
      int n;
      n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_busy"}, busy, 1);
   endtask

   task automatic measure_expect(input string nm, input int ch, input int res, input bit to,
                                 output int lat);
      bit got;
      int n;
      wait_valid(400, got, n);
      lat = n;
      chk({nm, "_valid"}, got, 1);
      if (got) begin
         chk({nm, "_result"}, result, res);
         chk({nm, "_ch"}, result_ch, ch);
         chk({nm, "_timeout"}, timeout, to);
      end
      last_served = ch;
   endtask

   initial begin
      int lat;
      int exp_ch;
      int cnt;
      logic [5:0] mask;

      RST    = 1'b1;
      PWRDWN = 1'b0;
      req    = '0;
      for (int g = 0; g < 6; g++) per[g] = 8;
      last_served = 5;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_result_ch", result_ch, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_timeout", timeout, 0);
      RST = 1'b0;
      repeat (2) @(negedge clk);

      // Round robin from reset: 0, 2, 5, 0 at period 4
      for (int g = 0; g < 6; g++) per[g] = 4;
      req = 6'b100101;
      for (int k = 0; k < 4; k++) begin
         exp_ch = next_grant(last_served, req);
         measure_expect($sformatf("rr%0d", k), exp_ch, 4, 1'b0, lat);
      end
      req = '0;
      repeat (3) @(negedge clk);

      // Table: single-channel measurements incl. min period and stopped signal
      tbl[0] = '{6'b000001, 0, 8, 8, 1'b0};
      tbl[1] = '{6'b000100, 2, 5, 5, 1'b0};
      tbl[2] = '{6'b100000, 5, 2, 2, 1'b0};
      tbl[3] = '{6'b001000, 3, 0, 0, 1'b1};
      tbl[4] = '{6'b010000, 4, 12, 12, 1'b0};
      tbl[5] = '{6'b000010, 1, 3, 3, 1'b0};
      for (int v = 0; v < 6; v++) begin
         per[tbl[v].ch] = tbl[v].period;
         @(negedge clk);
         req = tbl[v].rq;
         measure_expect($sformatf("tbl%0d", v), tbl[v].ch, tbl[v].exp_res, tbl[v].exp_to, lat);
         if (tbl[v].exp_to) chk_rng($sformatf("tbl%0d_to_latency", v), lat, 100, 108);
         req = '0;
         repeat (3) @(negedge clk);
      end
      per[3] = 8;

      // Randomized masks and periods against the round-robin/period model
      for (int it = 0; it < 6; it++) begin
         mask = 6'($urandom_range(1, 63));
         for (int g = 0; g < 6; g++) per[g] = int'($urandom_range(2, 12));
         @(negedge clk);
         req = mask;
         for (int k = 0; k < 4; k++) begin
            exp_ch = next_grant(last_served, mask);
            measure_expect($sformatf("rnd%0d_%0d", it, k), exp_ch, per[exp_ch], 1'b0, lat);
         end
         req = '0;
         repeat (3) @(negedge clk);
      end

      // Abort: drop req[1] in MEASURE
      per[1] = 8;
      @(negedge clk);
      req = 6'b000010;
      wait_busy("abort_start");
      repeat (30) @(negedge clk);
      req = '0;
      @(negedge clk);
      chk("abort_busy_low", busy, 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (result_valid) cnt++;
         @(negedge clk);
      end
      chk("abort_no_report", cnt, 0);
      req = 6'b000010;
      measure_expect("abort_redo", 1, 8, 1'b0, lat);
      req = '0;
      repeat (3) @(negedge clk);

      // PWRDWN pulse during DISCARD
      per[0] = 8;
      req = 6'b000001;
      wait_busy("pd_start");
      repeat (5) @(negedge clk);
      PWRDWN = 1'b1;
      @(negedge clk);
      chk("pd_busy_low", busy, 0);
      chk("pd_no_valid0", result_valid, 0);
      @(negedge clk);
      chk("pd_busy_held", busy, 0);
      chk("pd_no_valid1", result_valid, 0);
      PWRDWN = 1'b0;
      @(negedge clk);
      chk("pd_regrant_busy", busy, 1);
      chk("pd_regrant_sel", sel, 0);
      measure_expect("pd_redo", 0, 8, 1'b0, lat);
      req = '0;
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-MEASURE
      per[0] = 8;
      per[2] = 8;
      req = 6'b000100;
      wait_busy("rst2_start");
      repeat (30) @(negedge clk);
      #2 RST = 1'b1;
      #1;
      chk("rst2_sel", sel, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_result", result, 0);
      chk("rst2_result_ch", result_ch, 0);
      chk("rst2_valid", result_valid, 0);
      chk("rst2_timeout", timeout, 0);
      req = '0;
      @(negedge clk);
      RST = 1'b0;
      last_served = 5;
      @(negedge clk);
      req = 6'b000101;
      exp_ch = next_grant(last_served, req);
      wait_busy("rst2_grant");
      chk("rst2_grant_sel", sel, exp_ch);
      measure_expect("rst2_meas", exp_ch, 8, 1'b0, lat);
      req = '0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
